sseg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the board's 4-digit common-anode 7-seg display.

---
 rtl/sseg_scan_ctrl_pkg.sv | 7 +
 rtl/sseg_scan_ctrl_if.sv | 18 +
 rtl/sseg_scan_ctrl_bcd2sseg.sv | 27 ++
 rtl/sseg_scan_ctrl.sv | 75 +++++++
 tb/tb_sseg_scan_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/sseg_scan_ctrl_pkg.sv
// sseg_scan_ctrl_pkg: shared constants and scan state type for the 7-seg scan controller
package sseg_scan_ctrl_pkg;
  localparam int NDIG = 4;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'hF;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// sseg_scan_ctrl_if: digit/control inputs and display pins of the scan controller
interface sseg_scan_ctrl_if;
  import sseg_scan_ctrl_pkg::*;
  logic en;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0] dp_in;
  logic [NDIG-1:0] blink_mask;
  logic lzb_en;
  logic [6:0] seg_n;
  logic dp_n;
  logic [NDIG-1:0] an_n;
  logic [1:0] digit_sel;
  logic frame_tick;
  modport master (output en, digits, dp_in, blink_mask, lzb_en,
                  input seg_n, dp_n, an_n, digit_sel, frame_tick);
  modport slave (input en, digits, dp_in, blink_mask, lzb_en,
                 output seg_n, dp_n, an_n, digit_sel, frame_tick);
endinterface

// File: rtl/sseg_scan_ctrl_bcd2sseg.sv
// bcd2sseg: nibble to active-high abcdefg segments (MSB=a), hex glyphs above 9
module bcd2sseg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    case (bcd)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      default: seg = 7'h47;
    endcase
  end
endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: 4-digit multiplexed 7-seg scanner with ghost blanking, LZB and blink
module sseg_scan_ctrl import sseg_scan_ctrl_pkg::*; #(
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 64,
  parameter int BLINK_DIV = 25
) (
  input  logic clk,
  input  logic reset_n,
  sseg_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(PRESCALE);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);
  state_t state, ph;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [BW-1:0] bcnt;
  logic blink_phase;
  logic [15:0] sh_digits, cur_digits;
  logic [3:0] sh_dp, sh_mask, cur_dp, cur_mask;
  logic sh_lzb, cur_lzb;
  logic first, wrap, frame, lz_dark, lit;
  logic [3:0] nib;
  logic [6:0] seg;
  bcd2sseg u_dec (.bcd(nib), .seg(seg));
  // first enabled cycle bypasses the shadow so a zero-length blank still shows fresh data
  always_comb begin
    first = bus.en && state == IDLE;
    wrap = cnt == CNT_MAX;
    frame = bus.en && wrap && idx == 2'd3;
    ph = !bus.en ? IDLE : cnt < CNT_BLANK ? BLANK : DRIVE;
    cur_digits = first ? bus.digits : sh_digits;
    cur_dp = first ? bus.dp_in : sh_dp;
    cur_mask = first ? bus.blink_mask : sh_mask;
    cur_lzb = first ? bus.lzb_en : sh_lzb;
    nib = cur_digits[{idx, 2'b00} +: 4];
    lz_dark = cur_lzb && (idx == 2'd3 ? cur_digits[15:12] == '0 :
                          idx == 2'd2 ? cur_digits[15:8] == '0 :
                          idx == 2'd1 ? cur_digits[15:4] == '0 : 1'b0);
    lit = ph == DRIVE && !lz_dark && !(blink_phase && cur_mask[idx]);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      bcnt <= '0;
      blink_phase <= 1'b0;
      sh_digits <= '0;
      sh_dp <= '0;
      sh_mask <= '0;
      sh_lzb <= 1'b0;
      bus.an_n <= AN_OFF;
      bus.seg_n <= SEG_OFF;
      bus.dp_n <= 1'b1;
      bus.digit_sel <= '0;
      bus.frame_tick <= 1'b0;
    end else begin
      state <= ph;
      cnt <= (!bus.en || wrap) ? '0 : cnt + 1'b1;
      idx <= !bus.en ? '0 : wrap ? idx + 1'b1 : idx;
      if (first || frame) {sh_digits, sh_dp, sh_mask, sh_lzb} <= {bus.digits, bus.dp_in, bus.blink_mask, bus.lzb_en};
      if (frame) begin
        bcnt <= bcnt == BLK_MAX ? '0 : bcnt + 1'b1;
        blink_phase <= blink_phase ^ (bcnt == BLK_MAX);
      end
      bus.an_n <= lit ? ~(4'b1 << idx) : AN_OFF;
      bus.seg_n <= lit ? ~seg : SEG_OFF;
      bus.dp_n <= !(lit && cur_dp[idx]);
      bus.digit_sel <= idx;
      bus.frame_tick <= frame;
    end
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: scoreboard bench, per-slot expectations queued by stimulus, checked by a monitor
module tb_sseg_scan_ctrl;
  typedef struct packed {
    logic [1:0] slot;
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
  } exp_t;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int n_ticks = 0;
  exp_t exp_q[$];
  sseg_scan_ctrl_if bus();
  sseg_scan_ctrl #(.PRESCALE(8), .BLANK_CYC(2), .BLINK_DIV(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic exp_t exp_slot(input int i, input logic [15:0] d, input logic [3:0] dp,
                                    input logic [3:0] mask, input logic lzb, input logic ph);
    logic dark;
    dark = (lzb && ((i == 3 && d[15:12] == 4'h0) || (i == 2 && d[15:8] == 8'h0) ||
                    (i == 1 && d[15:4] == 12'h0))) || (ph && mask[i]);
    exp_slot.slot = 2'(i);
    exp_slot.an = dark ? 4'hF : ~(4'b1 << i);
    exp_slot.seg = dark ? 7'h7F : SEG_TAB[d[i*4 +: 4]];
    exp_slot.dp = dark ? 1'b1 : ~dp[i];
  endfunction

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.frame_tick !== 1'b1 && k < 100);
    if (bus.frame_tick !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick_timeout: got no frame_tick in %0d cycles, want one per 32", k);
    end
  endtask

  // the frame starting after this tick shows whatever inputs were present at the tick
  task automatic frame();
    wait_tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(exp_slot(i, bus.digits, bus.dp_in, bus.blink_mask, bus.lzb_en, n_ticks[1]));
  endtask

  task automatic enable_check(input logic [6:0] seg0);
    bus.en = 1'b1;
    @(negedge clk);
    chk("en_blank0_an", 16'(bus.an_n), 16'hF);
    @(negedge clk);
    chk("en_blank1_an", 16'(bus.an_n), 16'hF);
    @(negedge clk);
    chk("en_drive_an", 16'(bus.an_n), 16'hE);
    chk("en_drive_seg", 16'(bus.seg_n), 16'(seg0));
  endtask

  int pos = -1;
  int off;
  logic ok;
  logic [3:0] an_c;
  logic [6:0] seg_c;
  logic dp_c;
  exp_t e;
  // monitor: follows the frame after each tick, summarises every slot and pops one expectation
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      pos = -1;
      n_ticks = 0;
    end else begin
      if (pos >= 0) begin
        off = pos % 8;
        if (off == 0) ok = 1'b1;
        ok &= (bus.digit_sel == 2'(pos / 8)) && (bus.frame_tick == (pos == 31));
        if (off < 2) ok &= bus.an_n == 4'hF && bus.seg_n == 7'h7F && bus.dp_n == 1'b1;
        else if (off == 2) {an_c, seg_c, dp_c} = {bus.an_n, bus.seg_n, bus.dp_n};
        else ok &= {bus.an_n, bus.seg_n, bus.dp_n} == {an_c, seg_c, dp_c};
        if (off == 7 && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_cmp++;
          if (!ok || an_c !== e.an || seg_c !== e.seg || dp_c !== e.dp) begin
            n_bad++;
            $display("FAIL slot%0d: got timing_ok=%b an_n=%b seg_n=%b dp_n=%b want timing_ok=1 an_n=%b seg_n=%b dp_n=%b",
                     e.slot, ok, an_c, seg_c, dp_c, e.an, e.seg, e.dp);
          end
        end
        pos = pos == 31 ? -1 : pos + 1;
      end
      if (bus.frame_tick === 1'b1) begin
        pos = 0;
        n_ticks++;
      end
    end
  end

  initial begin
    bus.en = 1'b0;
    bus.digits = 16'h1234;
    bus.dp_in = 4'b0100;
    bus.blink_mask = 4'b0000;
    bus.lzb_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_an", 16'(bus.an_n), 16'hF);
    chk("rst_seg", 16'(bus.seg_n), 16'h7F);
    chk("rst_dp", 16'(bus.dp_n), 16'h1);
    chk("rst_sel", 16'(bus.digit_sel), 16'h0);
    chk("rst_tick", 16'(bus.frame_tick), 16'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    enable_check(7'b1001100);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_an", 16'(bus.an_n), 16'hF);
    chk("arst_seg", 16'(bus.seg_n), 16'h7F);
    chk("arst_dp", 16'(bus.dp_n), 16'h1);
    bus.en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_an", 16'(bus.an_n), 16'hF);
    chk("idle_seg", 16'(bus.seg_n), 16'h7F);
    chk("idle_dp", 16'(bus.dp_n), 16'h1);
    bus.en = 1'b1;
    repeat (2) frame();
    bus.digits = 16'h9ABC;
    frame();
    bus.digits = 16'hDEF0;
    frame();
    bus.lzb_en = 1'b1;
    bus.digits = 16'h0050;
    frame();
    bus.digits = 16'h0000;
    frame();
    bus.digits = 16'h0102;
    frame();
    bus.lzb_en = 1'b0;
    bus.digits = 16'h1234;
    bus.blink_mask = 4'b1100;
    repeat (4) frame();
    bus.blink_mask = 4'b0000;
    frame();
    repeat (11) @(negedge clk);
    bus.digits = 16'h5678;
    frame();
    wait_tick();
    repeat (20) @(negedge clk);
    chk("drop_pre_an", 16'(bus.an_n), 16'hB);
    bus.en = 1'b0;
    @(negedge clk);
    chk("drop_an", 16'(bus.an_n), 16'hF);
    chk("drop_seg", 16'(bus.seg_n), 16'h7F);
    chk("drop_dp", 16'(bus.dp_n), 16'h1);
    repeat (3) @(negedge clk);
    enable_check(7'b0000000);
    frame();
    for (int k = 0; k < 80 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d slots unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
